// File: rtl/sext_pipe_if.sv
// rtl/sext_pipe_if.sv - Handshake bundle for the sext_pipe immediate generator
// Purpose: groups the input and output valid/ready streams of sext_pipe.
// Parameters: XLEN (immediate width), TAG_W (side-band tag width).
// Signals:
//   in_valid/in_ready/din/EXTop/in_tag          - input entry stream
//   out_valid/out_ready/out_imm/out_illegal/out_tag - output entry stream
// Modports: master (producer of entries / consumer of results), slave (sext_pipe).
interface sext_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      din;
    logic [2:0]       EXTop;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, din, EXTop, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, din, EXTop, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_illegal, out_tag
    );
endinterface

// File: rtl/sext_pipe.sv
// rtl/sext_pipe.sv - Elastic sign-extending immediate generator with 2-entry skid
// Purpose: decodes the I/S/B/U/J immediate of an instruction word, sign-extends
//   it to XLEN and presents it one cycle after acceptance together with a
//   pass-through tag. A main register (M) and a skid register (K) give full
//   throughput under backpressure with in_ready depending on registered state only.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   flush  - synchronous flush, drops every held entry
//   bus    - sext_pipe_if.slave: input stream (in_valid/in_ready/din/EXTop/in_tag)
//            and output stream (out_valid/out_ready/out_imm/out_illegal/out_tag)
// Optional feature: SEXT_ZIMM_EN enables EXTop 101 as the CSR zero-extended zimm.
module sext_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    sext_pipe_if.slave   bus
);

    // Format decode: build a 32-bit signed value, then widen with sign extension.
    logic signed [31:0] raw;
    logic               dec_ill;
    logic [XLEN-1:0]    dec_imm;
    logic [31:0]        d;

    assign d = bus.din;

    always_comb begin
        raw     = '0;
        dec_ill = 1'b0;
        case (bus.EXTop)
            3'b000: raw = {{20{d[31]}}, d[31:20]};
            3'b001: raw = {{20{d[31]}}, d[31:25], d[11:7]};
            3'b010: raw = {{19{d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
            3'b011: raw = {d[31:12], 12'b0};
            3'b100: raw = {{11{d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
`ifdef SEXT_ZIMM_EN
            3'b101: raw = {27'b0, d[19:15]};
`endif
            default: dec_ill = 1'b1;
        endcase
    end

    assign dec_imm = XLEN'(raw);

    // Opcode field carries no immediate bits.
    logic unused_din_bits;
    assign unused_din_bits = ^d[6:0];

    // Storage: M drives the outputs, K absorbs the entry accepted while M stalls.
    logic             m_vld_q, m_vld_d, k_vld_q, k_vld_d;
    logic [XLEN-1:0]  m_imm_q, m_imm_d, k_imm_q, k_imm_d;
    logic             m_ill_q, m_ill_d, k_ill_q, k_ill_d;
    logic [TAG_W-1:0] m_tag_q, m_tag_d, k_tag_q, k_tag_d;

    logic accept, deliver;

    assign bus.in_ready    = ~k_vld_q;
    assign bus.out_valid   = m_vld_q;
    assign bus.out_imm     = m_imm_q;
    assign bus.out_illegal = m_ill_q;
    assign bus.out_tag     = m_tag_q;

    assign accept  = bus.in_valid & ~k_vld_q;
    assign deliver = m_vld_q & bus.out_ready;

    always_comb begin
        m_vld_d = m_vld_q;
        k_vld_d = k_vld_q;
        m_imm_d = m_imm_q;
        m_ill_d = m_ill_q;
        m_tag_d = m_tag_q;
        k_imm_d = k_imm_q;
        k_ill_d = k_ill_q;
        k_tag_d = k_tag_q;
        if (flush) begin
            // Data registers keep their contents; only occupancy is dropped.
            m_vld_d = 1'b0;
            k_vld_d = 1'b0;
        end else if (deliver && k_vld_q) begin
            // in_ready is low whenever K is full, so no accept can collide here.
            m_vld_d = 1'b1;
            k_vld_d = 1'b0;
            m_imm_d = k_imm_q;
            m_ill_d = k_ill_q;
            m_tag_d = k_tag_q;
        end else if (deliver || !m_vld_q) begin
            m_vld_d = accept;
            if (accept) begin
                m_imm_d = dec_imm;
                m_ill_d = dec_ill;
                m_tag_d = bus.in_tag;
            end
        end else if (accept) begin
            k_vld_d = 1'b1;
            k_imm_d = dec_imm;
            k_ill_d = dec_ill;
            k_tag_d = bus.in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld_q <= 1'b0;
            k_vld_q <= 1'b0;
            m_imm_q <= '0;
            m_ill_q <= 1'b0;
            m_tag_q <= '0;
            k_imm_q <= '0;
            k_ill_q <= 1'b0;
            k_tag_q <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            k_vld_q <= k_vld_d;
            m_imm_q <= m_imm_d;
            m_ill_q <= m_ill_d;
            m_tag_q <= m_tag_d;
            k_imm_q <= k_imm_d;
            k_ill_q <= k_ill_d;
            k_tag_q <= k_tag_d;
        end
    end

endmodule

// File: tb/tb_sext_pipe.sv
// tb/tb_sext_pipe.sv - Scoreboard testbench for sext_pipe
module tb_sext_pipe;
    localparam int XLEN  = 64;
    localparam int TAG_W = 8;

    typedef struct {
        logic [XLEN-1:0]  imm;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;

    sext_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    sext_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   n_deliv = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, got, exp, $time);
        end
    endtask

    // Reference decode built from arithmetic shifts of the signed word.
    function automatic exp_t model(input logic [31:0] d, input logic [2:0] op, input logic [TAG_W-1:0] t);
        exp_t e;
        logic signed [31:0] s;
        logic [31:0] r;
        s = d;
        r = '0;
        e.ill = 1'b0;
        case (op)
            3'd0: r = 32'(s >>> 20);
            3'd1: r = 32'((s >>> 25) <<< 5) | 32'(d[11:7]);
            3'd2: r = 32'((s >>> 31) <<< 12) | (32'(d[7]) << 11) | (32'(d[30:25]) << 5) | (32'(d[11:8]) << 1);
            3'd3: r = d & 32'hFFFF_F000;
            3'd4: r = 32'((s >>> 31) <<< 20) | (32'(d[19:12]) << 12) | (32'(d[20]) << 11) | (32'(d[30:21]) << 1);
`ifdef SEXT_ZIMM_EN
            3'd5: r = 32'(d[19:15]);
`endif
            default: e.ill = 1'b1;
        endcase
        e.imm = {{(XLEN-32){r[31]}}, r};
        e.tag = t;
        return e;
    endfunction

    // Monitor: push on accept, pop/compare on deliver, both decided at negedge.
    logic             hold_pend = 1'b0;
    logic [XLEN-1:0]  hold_imm;
    logic [TAG_W-1:0] hold_tag;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hold_pend = 1'b0;
        end else if (flush) begin
            sb.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_imm", 64'(bus.out_imm), 64'(hold_imm));
                check("hold_tag", 64'(bus.out_tag), 64'(hold_tag));
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_imm  = bus.out_imm;
            hold_tag  = bus.out_tag;
            if (bus.out_valid && bus.out_ready) begin
                exp_t e;
                n_deliv++;
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("imm", 64'(bus.out_imm), 64'(e.imm));
                    check("illegal", 64'(bus.out_illegal), 64'(e.ill));
                    check("tag", 64'(bus.out_tag), 64'(e.tag));
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.din, bus.EXTop, bus.in_tag));
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] d, input logic [2:0] op, input logic [TAG_W-1:0] t);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.din      = d;
        bus.EXTop    = op;
        bus.in_tag   = t;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_expect(input logic [31:0] d, input logic [2:0] op, input logic [TAG_W-1:0] t,
                               input logic [63:0] exp_imm, input logic exp_ill);
        send(d, op, t);
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("vec_imm", 64'(bus.out_imm), exp_imm);
        check("vec_ill", 64'(bus.out_illegal), 64'(exp_ill));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic drv_done;
    int   base;

    initial begin
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.EXTop     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_imm", 64'(bus.out_imm), 64'd0);
        check("rst_tag", 64'(bus.out_tag), 64'd0);
        check("rst_illegal", 64'(bus.out_illegal), 64'd0);
        rst = 1'b0;
        idle(1);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed formats with out_ready high.
        bus.out_ready = 1'b1;
        send_expect(32'hFFF00093, 3'b000, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_expect(32'hFE112C23, 3'b001, 8'h11, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        send_expect(32'hFFDFF06F, 3'b100, 8'h12, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send_expect(32'h80000037, 3'b011, 8'h13, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send_expect(32'h12345037, 3'b011, 8'h14, 64'h0000_0000_1234_5000, 1'b0);
        send_expect(32'h8000_0863, 3'b010, 8'h15, 64'hFFFF_FFFF_FFFF_F010, 1'b0);
        send_expect(32'hFFFF_FFFF, 3'b111, 8'h16, 64'h0, 1'b1);
`ifdef SEXT_ZIMM_EN
        send_expect(32'h000A_8073, 3'b101, 8'h17, 64'h15, 1'b0);
`else
        send_expect(32'h000A_8073, 3'b101, 8'h17, 64'h0, 1'b1);
`endif

        // Backpressure: tags 1,2,3 back-to-back, release after K fills.
        bus.out_ready = 1'b0;
        fork
            begin
                send(32'h0010_0093, 3'b000, 8'd1);
                send(32'h0020_0093, 3'b000, 8'd2);
                send(32'h0030_0093, 3'b000, 8'd3);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                check("bp_head_tag", 64'(bus.out_tag), 64'd1);
                base = n_deliv;
                bus.out_ready = 1'b1;
                idle(3);
                check("bp_one_per_cycle", 64'(n_deliv - base), 64'd3);
            end
        join
        idle(2);

        // Flush with M and K full while an entry is offered.
        bus.out_ready = 1'b0;
        send(32'h0050_0093, 3'b000, 8'h21);
        send(32'h0060_0093, 3'b000, 8'h22);
        base = n_deliv;
        bus.in_valid = 1'b1; bus.din = 32'h0070_0093; bus.EXTop = 3'b000; bus.in_tag = 8'h23;
        flush = 1'b1;
        idle(1);
        flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_keeps_data", 64'(bus.out_tag), 64'h21);
        // Flush colliding with a real accept into an empty K.
        send(32'h0080_0093, 3'b000, 8'h24);
        bus.in_valid = 1'b1; bus.din = 32'h0090_0093; bus.in_tag = 8'h25;
        flush = 1'b1;
        idle(1);
        flush = 1'b0; bus.in_valid = 1'b0;
        check("flush2_out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        idle(5);
        check("flush_no_emit", 64'(n_deliv - base), 64'd0);

        // Random traffic with random backpressure.
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    idle($urandom_range(0, 2));
                    send($urandom, 3'($urandom_range(0, 7)), 8'(i));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        begin
            int n = 0;
            while (sb.size() != 0 && n < 50) begin
                idle(1);
                n++;
            end
            check("drain_empty", 64'(sb.size()), 64'd0);
        end

        // Reset in the middle of a held transfer.
        bus.out_ready = 1'b0;
        send(32'hFFF0_0093, 3'b000, 8'h31);
        send(32'hFFF0_0093, 3'b000, 8'h32);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_imm", 64'(bus.out_imm), 64'd0);
        check("midrst_tag", 64'(bus.out_tag), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        base = n_deliv;
        bus.out_ready = 1'b1;
        idle(3);
        check("midrst_no_emit", 64'(n_deliv - base), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
